// File: rtl/serial_add_sequencer.sv
// Bit-serial-by-nibble wide adder: one shared 4-bit ripple adder is stepped across the operands, LSB slice first.
// Optional signed-overflow flag is compiled in with `define OVERFLOW_DETECT_EN.

module ripple_carry_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

module serial_add_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSLICE = WIDTH / 4;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    logic [CW+1:0]    base;
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic [3:0]       slice_sum;
    logic             slice_cout;
    logic [WIDTH-1:0] next_res;
    logic             accept;

    assign base     = {cnt, 2'b00};
    assign slice_a  = op_a[base +: 4];
    assign slice_b  = op_b[base +: 4];
    // Each slice result enters at the top, so after NSLICE shifts slice 0 sits at the LSB.
    assign next_res = {slice_sum, res[WIDTH-1:4]};
    assign accept   = start && (state == IDLE || state == DONE);

    ripple_carry_adder u_rca (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            carry  <= 1'b0;
            op_a   <= '0;
            op_b   <= '0;
            res    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b;
            carry <= cin;
            cnt   <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    res   <= next_res;
                    carry <= slice_cout;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= next_res;
                        cout_q <= slice_cout;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef OVERFLOW_DETECT_EN
    logic ovf_q;
    logic ovf_next;

    assign ovf_next = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (next_res[WIDTH-1] != op_a[WIDTH-1]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (!accept && state == RUN && cnt == LAST)
            ovf_q <= ovf_next;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy = (state == RUN);
    assign done = (state == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Self-checking bench for serial_add_sequencer (WIDTH=16): table of directed sums plus
// hand-written back-to-back and reset-abort sequences.

module tb_serial_add_sequencer;

`ifdef OVERFLOW_DETECT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] sum;
        logic        cout;
        logic        sovf;
    } vec_t;

    vec_t vecs[8];

    serial_add_sequencer #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Waits (bounded) for done, counting edges from the accepting edge inclusive.
    task automatic wait_done(output int edges, output int busy_cnt);
        edges    = 1;
        busy_cnt = 0;
        while (!done && edges < 20) begin
            if (busy) busy_cnt++;
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic run_op(input vec_t v);
        logic [15:0] prev_sum;
        int edges;
        int busy_cnt;
        @(negedge clk);
        prev_sum = sum;
        a = v.a; b = v.b; cin = v.cin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~v.a; b = v.a ^ 16'h5A5A; cin = ~v.cin;
        check({v.name, "_hold_in_run"}, 32'(sum), 32'(prev_sum));
        wait_done(edges, busy_cnt);
        check({v.name, "_latency"}, 32'(edges), 32'd5);
        check({v.name, "_busy_cycles"}, 32'(busy_cnt), 32'd4);
        check({v.name, "_sum"}, 32'(sum), 32'(v.sum));
        check({v.name, "_cout"}, 32'(cout), 32'(v.cout));
        check({v.name, "_ovf"}, 32'(ovf), 32'(v.sovf & OVF_EN));
        @(negedge clk);
        check({v.name, "_done_pulse"}, 32'(done), 32'd0);
        check({v.name, "_sum_held"}, 32'(sum), 32'(v.sum));
    endtask

    initial begin
        int edges;
        int busy_cnt;
        bit seen_done;
        vec_t last;

        vecs[0] = '{"add3_3",     16'h0003, 16'h0003, 1'b0, 16'h0006, 1'b0, 1'b0};
        vecs[1] = '{"ffff_1",     16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{"7fff_1",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{"8000_8000",  16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{"00f0_0010",  16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[5] = '{"5555_aaaa",  16'h5555, 16'hAAAA, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[6] = '{"4000_4000",  16'h4000, 16'h4000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[7] = '{"ffff_ffff1", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum",  32'(sum),  32'd0);
        check("reset_cout", 32'(cout), 32'd0);
        check("reset_ovf",  32'(ovf),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Back-to-back: start held high, second op accepted in DONE.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        check("b2b_busy1", 32'(busy), 32'd1);
        check("b2b_hold_prev", 32'(sum), 32'h0000_FFFF);
        wait_done(edges, busy_cnt);
        check("b2b_lat1", 32'(edges), 32'd5);
        check("b2b_sum1", 32'(sum), 32'h1235);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", 32'(busy), 32'd1);
        wait_done(edges, busy_cnt);
        check("b2b_lat2", 32'(edges), 32'd5);
        check("b2b_sum2", 32'(sum), 32'h1235);
        check("b2b_cout2", 32'(cout), 32'd0);
        @(negedge clk);

        // Reset in the 2nd RUN cycle aborts the op with no done pulse.
        a = 16'h00FF; b = 16'h0001; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum",  32'(sum),  32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        check("rst_no_done", 32'(seen_done), 32'd0);

        last = '{"after_rst", 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0};
        run_op(last);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
